// File: rtl/sad_pkg.sv
// Shared types and helpers for the per-disparity SAD cost generator.
package sad_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   // Accumulator width that holds WIN full-scale absolute differences exactly.
   function automatic int acc_w(input int pix_w, input int win);
      return pix_w + $clog2(win);
   endfunction

   function automatic logic [31:0] ad_max(input int pix_w);
      return (32'd1 << pix_w) - 32'd1;
   endfunction

   // Clamp an unsigned sum to the largest value representable in dw bits.
   function automatic logic [31:0] sat(input logic [31:0] v, input int dw);
      logic [31:0] mx;
      mx = (32'd1 << dw) - 32'd1;
      return (v > mx) ? mx : v;
   endfunction

endpackage

// File: rtl/sad_disp_lane.sv
// One disparity: stage-1 absolute difference, stage-2 sliding window sum and
// saturated output register.
module sad_disp_lane
   import sad_pkg::*;
#(
   parameter int PIX_WIDTH  = 8,
   parameter int WIN        = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en1,
   input  logic                  invalid,
   input  logic [PIX_WIDTH-1:0]  left,
   input  logic [PIX_WIDTH-1:0]  rpix,
   input  logic                  en2,
   input  logic                  clr2,
   input  logic                  out_en,
   output logic [DATA_WIDTH-1:0] sad
);
   localparam int AW = acc_w(PIX_WIDTH, WIN);
   localparam logic [PIX_WIDTH-1:0] AD_MAX = PIX_WIDTH'(ad_max(PIX_WIDTH));

   logic [PIX_WIDTH-1:0]          ad_new, ad_s1, oldest;
   logic [WIN-1:0][PIX_WIDTH-1:0] hist, hist_nxt;
   logic [AW-1:0]                 acc, base, acc_nxt;

   always_comb begin
      if (invalid)           ad_new = AD_MAX;
      else if (left >= rpix) ad_new = left - rpix;
      else                   ad_new = rpix - left;
   end

   // A line start empties the window before the first difference enters it.
   always_comb begin
      oldest   = clr2 ? '0 : hist[WIN-1];
      base     = clr2 ? '0 : acc;
      acc_nxt  = base + AW'(ad_s1) - AW'(oldest);
      hist_nxt = clr2 ? '0 : hist;
      hist_nxt = {hist_nxt[WIN-2:0], ad_s1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ad_s1 <= '0;
         hist  <= '0;
         acc   <= '0;
         sad   <= '0;
      end else begin
         if (en1) ad_s1 <= ad_new;
         if (en2) begin
            acc  <= acc_nxt;
            hist <= hist_nxt;
         end
         if (out_en) sad <= DATA_WIDTH'(sat(32'(acc_nxt), DATA_WIDTH));
      end
   end

endmodule

// File: rtl/sad_window_gen.sv
// Streaming per-disparity horizontal-window SAD generator: right delay line,
// column counter, line FSM and two-stage valid pipeline around ELEM lanes.
module sad_window_gen
   import sad_pkg::*;
#(
   parameter int ELEM       = 64,
   parameter int DATA_WIDTH = 8,
   parameter int PIX_WIDTH  = 8,
   parameter int WIN        = 8,
   parameter int IMG_WIDTH  = 640
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_valid,
   input  logic                             i_sol,
   input  logic [PIX_WIDTH-1:0]             i_left,
   input  logic [PIX_WIDTH-1:0]             i_right,
   output logic                             o_valid,
   output logic [ELEM-1:0][DATA_WIDTH-1:0]  o_sads_data,
   output logic [$clog2(IMG_WIDTH)-1:0]     o_col
);
   localparam int CW    = $clog2(IMG_WIDTH);
   localparam int RDL_W = (ELEM - 1) * PIX_WIDTH;
   localparam logic [CW-1:0] LAST_COL  = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] FIRST_OUT = CW'(WIN - 1);

   state_t                         state, state_nxt;
   logic [ELEM-2:0][PIX_WIDTH-1:0] rdl;
   logic [ELEM-1:0][PIX_WIDTH-1:0] rpix;
   logic [CW-1:0]                  col_cnt, cur_col, s1_col;
   logic                           sol_in, acc_en, s1_acc, s1_sol;
   logic [1:0]                     vld_pipe;

   // rpix[d] is the right pixel d columns behind the current one.
   assign rpix   = {rdl, i_right};
   assign sol_in = i_valid & i_sol;

   always_comb begin
      state_nxt = state;
      acc_en    = 1'b0;
      cur_col   = sol_in ? '0 : col_cnt;
      case (state)
         IDLE: if (sol_in) begin
            acc_en    = 1'b1;
            state_nxt = RUN;
         end
         RUN: acc_en = i_valid;
         default: state_nxt = IDLE;
      endcase
      if (acc_en && cur_col == LAST_COL) state_nxt = IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         col_cnt  <= '0;
         rdl      <= '0;
         s1_acc   <= 1'b0;
         s1_sol   <= 1'b0;
         s1_col   <= '0;
         vld_pipe <= '0;
         o_col    <= '0;
      end else begin
         state    <= state_nxt;
         s1_acc   <= acc_en;
         s1_sol   <= acc_en & i_sol;
         vld_pipe <= {vld_pipe[0], acc_en && (cur_col >= FIRST_OUT)};
         if (acc_en) begin
            s1_col  <= cur_col;
            col_cnt <= (cur_col == LAST_COL) ? cur_col : cur_col + 1'b1;
            rdl     <= i_sol ? RDL_W'(i_right) : rpix[ELEM-2:0];
         end
         if (vld_pipe[0]) o_col <= s1_col;
      end
   end

   assign o_valid = vld_pipe[1];

   for (genvar d = 0; d < ELEM; d++) begin : g_lane
      sad_disp_lane #(
         .PIX_WIDTH  (PIX_WIDTH),
         .WIN        (WIN),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk     (i_clk),
         .rst     (i_rst),
         .en1     (acc_en),
         .invalid (int'(cur_col) < d),
         .left    (i_left),
         .rpix    (rpix[d]),
         .en2     (s1_acc),
         .clr2    (s1_sol),
         .out_en  (vld_pipe[0]),
         .sad     (o_sads_data[d])
      );
   end

endmodule

// File: tb/tb_sad_window_gen.sv
// Directed bench for sad_window_gen with a reference window-sum scoreboard.
module tb_sad_window_gen;
   localparam int ELEM = 64, DW = 8, PW = 8, WIN = 8, IMGW = 640;
   localparam int CW = $clog2(IMGW);
   localparam int VW = ELEM * DW;
   localparam int ADM = (1 << PW) - 1;
   localparam int SATM = (1 << DW) - 1;

   logic clk = 1'b0;
   logic rst, valid, sol;
   logic [PW-1:0] left, right;
   logic o_valid;
   logic [ELEM-1:0][DW-1:0] o_sads;
   logic [CW-1:0] o_col;

   sad_window_gen #(
      .ELEM(ELEM), .DATA_WIDTH(DW), .PIX_WIDTH(PW), .WIN(WIN), .IMG_WIDTH(IMGW)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sol(sol),
      .i_left(left), .i_right(right),
      .o_valid(o_valid), .o_sads_data(o_sads), .o_col(o_col)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ELEM-1:0][DW-1:0] sads;
      int col;
      int cyc;
      int mode;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int ml[IMGW], mr[IMGW];
   int mcol = 0;
   bit mrun = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_i(string tag, int obs, int expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic chk_v(string tag, logic [VW-1:0] obs, logic [VW-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic int ad(int c, int d);
      if (c < d) return ADM;
      return (ml[c] > mr[c-d]) ? ml[c] - mr[c-d] : mr[c-d] - ml[c];
   endfunction

   task automatic push_exp(int x, int md);
      exp_t e;
      int s;
      for (int d = 0; d < ELEM; d++) begin
         s = 0;
         for (int k = 0; k < WIN; k++) s += ad(x - k, d);
         e.sads[d] = DW'((s > SATM) ? SATM : s);
      end
      e.col = x;
      e.cyc = cyc;
      e.mode = md;
      q.push_back(e);
   endtask

   task automatic drive(bit v, bit s, int l, int r, int md);
      @(posedge clk); #1;
      valid = v; sol = s; left = PW'(l); right = PW'(r);
      if (v) begin
         if (s) begin mcol = 0; mrun = 1; end
         if (mrun) begin
            ml[mcol] = l; mr[mcol] = r;
            if (mcol >= WIN - 1) push_exp(mcol, md);
            if (mcol == IMGW - 1) mrun = 0;
            else mcol++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (o_valid === 1'b1) begin
         n_cmp++;
         assert (q.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_valid: got o_valid=1 col %0d expected no output", o_col);
         end
         if (q.size() != 0) begin
            bit nz;
            mon_e = q.pop_front();
            chk_v("sads", o_sads, mon_e.sads);
            chk_i("col", int'(o_col), mon_e.col);
            chk_i("latency", cyc, mon_e.cyc + 2);
            if (mon_e.col == 7) chk_i("col7_d10_invalid", int'(o_sads[10]), SATM);
            if (mon_e.mode == 1) chk_i("ramp_d0", int'(o_sads[0]), 0);
            if (mon_e.mode == 2 && mon_e.col >= 12) begin
               nz = 1'b1;
               for (int d = 0; d < ELEM; d++) if (d != 5 && o_sads[d] == '0) nz = 1'b0;
               chk_i("shift_d5", int'(o_sads[5]), 0);
               chk_i("shift_others_nz", int'(nz), 1);
            end
            if (mon_e.mode == 3) chk_v("sat_all", o_sads, {ELEM{DW'(SATM)}});
         end
      end
   end

   initial begin
      int rcyc;
      rst = 1'b1; valid = 1'b0; sol = 1'b0; left = '0; right = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_i("rst_valid", int'(o_valid), 0);
      chk_v("rst_sads", o_sads, '0);
      chk_i("rst_col", int'(o_col), 0);
      @(posedge clk); #1 rst = 1'b0;

      // IDLE: pixels without a line start are dropped
      for (int i = 0; i < 5; i++) drive(1, 0, i, i, 0);

      // identical ramps over a full line, then stray pixels after the line ends
      for (int x = 0; x < IMGW; x++) drive(1, x == 0, x % 256, x % 256, 1);
      for (int i = 0; i < 3; i++) drive(1, 0, 9, 200, 0);
      drive(0, 0, 0, 0, 0);

      // right = left shifted by 5, cut short by the next line start
      for (int x = 0; x < 200; x++) drive(1, x == 0, x % 256, (x + 5) % 256, 2);

      // L=255, R=0 saturates every element
      for (int x = 0; x < 40; x++) drive(1, x == 0, 255, 0, 3);

      // random line with two 3-cycle stalls (sol held high while stalled)
      for (int x = 0; x < 60; x++) begin
         drive(1, x == 0, $urandom_range(0, 255), $urandom_range(0, 255), 0);
         if (x == 20 || x == 40)
            for (int k = 0; k < 3; k++) drive(0, 1, $urandom_range(0, 255), 0, 0);
      end

      // random line, reset at column 100 with a valid pixel present
      for (int x = 0; x < 100; x++)
         drive(1, x == 0, $urandom_range(0, 255), $urandom_range(0, 255), 0);
      @(posedge clk); #1;
      rst = 1'b1; valid = 1'b1; sol = 1'b0; left = 8'd77; right = 8'd3;
      rcyc = cyc;
      mrun = 0;
      @(posedge clk); #1;
      rst = 1'b0; valid = 1'b0;
      while (q.size() > 0 && q[$].cyc >= rcyc - 1) void'(q.pop_back());
      @(negedge clk);
      chk_i("rst_flush", int'(o_valid), 0);
      drive(0, 0, 0, 0, 0);
      for (int x = 0; x < 50; x++)
         drive(1, x == 0, $urandom_range(0, 255), $urandom_range(0, 255), 0);

      for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0);
      chk_i("drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
